// File: rtl/puf_pkg.sv
// Shared types and constants for the PUF read controller.
package puf_pkg;
  localparam int PUF_W = 1024;

  typedef enum logic [2:0] {IDLE, ARM, SAMPLE, RESOLVE, STREAM} state_t;

  function automatic int vote_w(input int n_samples);
    return $clog2(n_samples + 1);
  endfunction
endpackage

// File: rtl/puf_vote_cell.sv
// Single-bit snapshot vote counter with majority and unanimity outputs.
module puf_vote_cell
  import puf_pkg::*;
#(
  parameter int N_SAMPLES = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  input  logic d,
  output logic maj,
  output logic unan
);
  localparam int VW = vote_w(N_SAMPLES);

  logic [VW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (clr)        cnt <= '0;
    else if (inc && d)   cnt <= cnt + 1'b1;
  end

  assign maj  = (cnt > VW'(N_SAMPLES / 2));
  assign unan = (cnt == '0) || (cnt == VW'(N_SAMPLES));
endmodule

// File: rtl/puf_read_ctrl.sv
// PUF read sequencer: settle, multi-snapshot majority vote, then stream the key.
// state   | meaning
// IDLE    | waiting for start
// ARM     | array powered, oscillators settling
// SAMPLE  | array powered, snapshots accumulated into vote counters
// RESOLVE | majority key and unstable count registered
// STREAM  | key words offered over valid/ready
module puf_read_ctrl
  import puf_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int N_SAMPLES     = 5,
  parameter int SAMPLE_GAP    = 3,
  parameter int WORD_W        = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        challenge,
  output logic              busy,
  output logic              done,
  output logic              puf_enable,
  output logic [1:0]        puf_ctrl,
  input  logic [PUF_W-1:0]  puf_resp,
  output logic [WORD_W-1:0] key_word,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              key_last,
  output logic [10:0]       unstable_cnt
);
  localparam int N_WORDS = PUF_W / WORD_W;
  localparam int K_W     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  state_t             state;
  logic [1:0]         ch_q;
  logic [7:0]         tmr;
  logic [3:0]         snap_cnt;
  logic [K_W-1:0]     k;
  logic [PUF_W-1:0]   key_q;
  logic [PUF_W-1:0]   maj;
  logic [PUF_W-1:0]   unan;
  logic [10:0]        unstable_sum;
  logic               clr_votes;
  logic               snap;

  // A start coinciding with the done pulse is dropped; the next cycle may start.
  assign clr_votes = (state == IDLE) && start && !done;
  assign snap      = (state == SAMPLE) && (tmr == '0);

  for (genvar i = 0; i < PUF_W; i++) begin : g_vote
    puf_vote_cell #(.N_SAMPLES(N_SAMPLES)) u_cell (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clr_votes),
      .inc  (snap),
      .d    (puf_resp[i]),
      .maj  (maj[i]),
      .unan (unan[i])
    );
  end

  always_comb begin
    unstable_sum = '0;
    for (int i = 0; i < PUF_W; i++) unstable_sum = unstable_sum + {10'd0, ~unan[i]};
  end

  assign busy     = (state != IDLE);
  assign puf_ctrl = puf_enable ? ch_q : 2'b00;
  assign key_word = key_valid ? key_q[k*WORD_W +: WORD_W] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ch_q         <= '0;
      tmr          <= '0;
      snap_cnt     <= '0;
      k            <= '0;
      key_q        <= '0;
      puf_enable   <= 1'b0;
      key_valid    <= 1'b0;
      key_last     <= 1'b0;
      done         <= 1'b0;
      unstable_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_votes) begin
            ch_q       <= challenge;
            puf_enable <= 1'b1;
            tmr        <= 8'(SETTLE_CYCLES - 1);
            state      <= ARM;
          end
        end
        ARM: begin
          if (tmr == '0) begin
            snap_cnt <= '0;
            state    <= SAMPLE;
          end else begin
            tmr <= tmr - 8'd1;
          end
        end
        SAMPLE: begin
          if (snap) begin
            if (snap_cnt == 4'(N_SAMPLES - 1)) begin
              puf_enable <= 1'b0;
              state      <= RESOLVE;
            end else begin
              snap_cnt <= snap_cnt + 4'd1;
              tmr      <= 8'(SAMPLE_GAP);
            end
          end else begin
            tmr <= tmr - 8'd1;
          end
        end
        RESOLVE: begin
          key_q        <= maj;
          unstable_cnt <= unstable_sum;
          k            <= '0;
          key_valid    <= 1'b1;
          key_last     <= (N_WORDS == 1);
          state        <= STREAM;
        end
        STREAM: begin
          if (key_ready) begin
            if (key_last) begin
              key_valid <= 1'b0;
              key_last  <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end else begin
              k        <= k + 1'b1;
              key_last <= (k == K_W'(N_WORDS - 2));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_puf_read_ctrl.sv
// Directed-plus-random bench for puf_read_ctrl against a snapshot-history vote model.
module tb_puf_read_ctrl;
  localparam int PW          = 1024;
  localparam int SETTLE      = 16;
  localparam int NS          = 5;
  localparam int GAP         = 3;
  localparam int WW          = 32;
  localparam int NWORDS      = PW / WW;
  localparam int FIRST_SNAP  = 1 + SETTLE;
  localparam int LAST_EN     = 1 + SETTLE + (NS - 1) * (GAP + 1);
  localparam int FIRST_VALID = LAST_EN + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, start1;
  logic [1:0]    challenge, ch1;
  logic          busy, done, puf_enable, key_valid, key_ready, key_last;
  logic          busy1, done1, en1, valid1, ready1, last1;
  logic [1:0]    puf_ctrl, ctrl1;
  logic [PW-1:0] puf_resp, resp1;
  logic [WW-1:0] key_word, word1;
  logic [10:0]   unstable_cnt, unst1;

  puf_read_ctrl #(.SETTLE_CYCLES(SETTLE), .N_SAMPLES(NS), .SAMPLE_GAP(GAP), .WORD_W(WW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .challenge(challenge), .busy(busy), .done(done),
    .puf_enable(puf_enable), .puf_ctrl(puf_ctrl), .puf_resp(puf_resp), .key_word(key_word),
    .key_valid(key_valid), .key_ready(key_ready), .key_last(key_last), .unstable_cnt(unstable_cnt)
  );

  puf_read_ctrl #(.SETTLE_CYCLES(2), .N_SAMPLES(1), .SAMPLE_GAP(0), .WORD_W(WW)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .challenge(ch1), .busy(busy1), .done(done1),
    .puf_enable(en1), .puf_ctrl(ctrl1), .puf_resp(resp1), .key_word(word1),
    .key_valid(valid1), .key_ready(ready1), .key_last(last1), .unstable_cnt(unst1)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_err = 0;
  int            prev_unst = 0;
  int            exp_unst;
  logic [PW-1:0] exp_key;
  logic [PW-1:0] snaps[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] rand_vec();
    logic [PW-1:0] v;
    for (int i = 0; i < PW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Majority of the recorded snapshots per bit; unstable = bits not unanimous.
  task automatic model(input int n);
    exp_key  = '0;
    exp_unst = 0;
    for (int i = 0; i < PW; i++) begin
      int ones = 0;
      foreach (snaps[s]) ones += int'(snaps[s][i]);
      exp_key[i] = (2 * ones > n);
      if (ones != 0 && ones != n) exp_unst++;
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_enable", puf_enable, 0);
    check("rst_ctrl", puf_ctrl, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", key_valid, 0);
    check("rst_last", key_last, 0);
    check("rst_word", key_word, 0);
    check("rst_unstable", unstable_cnt, 0);
  endtask

  // mode 0: constant A5 pattern, 1: noisy random, 2/3: bit0 set in first `mode` snapshots only
  task automatic do_read(input logic [1:0] ch, input int mode, input int stall_at,
                         input int reset_at, input bit poke);
    logic [PW-1:0] base, v;
    int j, w, stall_left;
    base = rand_vec();
    snaps.delete();
    @(negedge clk);
    check("idle_busy", busy, 0);
    start = 1'b1; challenge = ch; key_ready = 1'b0;
    for (int c = 1; c < FIRST_VALID; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && c == 20) begin start = 1'b1; challenge = 2'b01; end
      check("enable", puf_enable, (c <= LAST_EN));
      check("ctrl", puf_ctrl, (c <= LAST_EN) ? ch : 2'b00);
      check("busy", busy, 1);
      check("valid_early", key_valid, 0);
      check("unst_hold", unstable_cnt, prev_unst);
      j = -1;
      if (c >= FIRST_SNAP && (c - FIRST_SNAP) % (GAP + 1) == 0) j = (c - FIRST_SNAP) / (GAP + 1);
      if (j >= NS) j = -1;
      case (mode)
        0: v = {128{8'hA5}};
        1: begin
          v = base;
          repeat (8) v[$urandom_range(PW - 1)] ^= 1'b1;
        end
        default: begin
          if (j >= 0) begin v = '0; v[0] = (j < mode); end
          else v = rand_vec();
        end
      endcase
      puf_resp = v;
      if (j >= 0) snaps.push_back(v);
    end
    start = 1'b0;
    model(NS);
    w = 0; stall_left = 4;
    while (w < NWORDS) begin
      @(negedge clk);
      check("valid", key_valid, 1);
      check("word", key_word, exp_key[w*WW +: WW]);
      check("last", key_last, (w == NWORDS - 1));
      check("unstable", unstable_cnt, exp_unst);
      check("stream_enable", puf_enable, 0);
      if (w == reset_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1; key_ready = 1'b0; prev_unst = 0;
        return;
      end
      if (w == stall_at && stall_left > 0) begin key_ready = 1'b0; stall_left--; end
      else begin key_ready = 1'b1; w++; end
    end
    @(negedge clk);
    key_ready = 1'b0;
    check("done", done, 1);
    check("valid_after", key_valid, 0);
    check("busy_after", busy, 0);
    repeat (3) begin
      @(negedge clk);
      check("done_once", done, 0);
      check("idle_after", busy, 0);
      check("unst_kept", unstable_cnt, exp_unst);
    end
    prev_unst = exp_unst;
  endtask

  initial begin
    logic [PW-1:0] r, v;
    rst_n = 1'b0; start = 1'b0; challenge = 2'b00; key_ready = 1'b0; puf_resp = '0;
    start1 = 1'b0; ch1 = 2'b00; ready1 = 1'b0; resp1 = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    check("rst_busy1", busy1, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_read(2'b10, 0, -1, -1, 1'b0);
    do_read(2'b01, 2, -1, -1, 1'b0);
    do_read(2'b11, 3, -1, -1, 1'b0);
    do_read(2'b00, 1, 7, -1, 1'b0);
    do_read(2'b10, 1, -1, -1, 1'b1);
    do_read(2'b11, 1, -1, 12, 1'b0);
    do_read(2'b01, 1, 3, -1, 1'b0);

    // single snapshot, no gap: key is the response on the first SAMPLE cycle
    r = '0;
    @(negedge clk);
    start1 = 1'b1; ch1 = 2'b11;
    for (int c = 1; c < 5; c++) begin
      @(negedge clk);
      start1 = 1'b0;
      check("en1", en1, (c <= 3));
      check("ctrl1", ctrl1, (c <= 3) ? 2'b11 : 2'b00);
      check("valid1_early", valid1, 0);
      v = rand_vec();
      resp1 = v;
      if (c == 3) r = v;
      if (c == 4) ready1 = 1'b1;
    end
    for (int w = 0; w < NWORDS; w++) begin
      @(negedge clk);
      check("valid1", valid1, 1);
      check("word1", word1, r[w*WW +: WW]);
      check("last1", last1, (w == NWORDS - 1));
      check("unst1", unst1, 0);
    end
    @(negedge clk);
    ready1 = 1'b0;
    check("done1", done1, 1);
    check("busy1_after", busy1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/puf_read_ctrl.md
Name: puf_read_ctrl

Overview:
Sequencing controller for the 1024-bit PUF generator array. On request it powers the array with a latched 2-bit challenge and waits for oscillators to settle. It then takes N_SAMPLES snapshots of the 1024-bit response and majority-votes each bit into a stabilised key. The key is streamed out as WORD_W-bit words over a valid/ready interface, together with a count of bits that were not unanimous across snapshots.

Parameters:
SETTLE_CYCLES, 16, cycles puf_enable is held high before the first snapshot (1..255)
N_SAMPLES, 5, snapshots per read; odd, 1..15
SAMPLE_GAP, 3, idle cycles between consecutive snapshots (0..255)
WORD_W, 32, output word width; must divide 1024

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a read; honoured only in IDLE
challenge  input  2  challenge value, latched on an accepted start
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse after the last word is accepted
puf_enable  output  1  drives the generator enable
puf_ctrl  output  2  drives the generator control_input
puf_resp  input  1024  generator output_signal
key_word  output  WORD_W  current key word
key_valid  output  1  key_word is valid
key_ready  input  1  downstream accepts key_word
key_last  output  1  high with the final word
unstable_cnt  output  11  number of non-unanimous bits in the last read (0..1024)

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: all outputs 0, state IDLE, vote counters 0. unstable_cnt keeps its value until the next RESOLVE.
- FSM states: IDLE, ARM, SAMPLE, RESOLVE, STREAM.
- IDLE: when start=1, latch challenge into ch_q, clear all vote counters, go to ARM.
- ARM: puf_enable=1 and puf_ctrl=ch_q. Stays for exactly SETTLE_CYCLES cycles, then goes to SAMPLE.
- SAMPLE: puf_enable=1.
  - Snapshots are taken on the first SAMPLE cycle and then every SAMPLE_GAP+1 cycles.
  - A snapshot increments vote counter i for each i where puf_resp[i]=1.
  - After the N_SAMPLES-th snapshot, go to RESOLVE.
  - SAMPLE duration is (N_SAMPLES-1)*(SAMPLE_GAP+1)+1 cycles.
- RESOLVE (1 cycle): puf_enable=0 and puf_ctrl=0.
  - key[i] = (cnt[i] > N_SAMPLES/2), using integer division.
  - unstable_cnt = number of i with cnt[i]≠0 and cnt[i]≠N_SAMPLES.
  - Key is registered; go to STREAM.
- STREAM: puf_enable stays 0.
  - key_valid=1 with key_word = key[WORD_W*k +: WORD_W], starting at k=0 (LSBs first).
  - A word transfers when key_valid && key_ready; k then increments.
  - key_last=1 when k = 1024/WORD_W−1.
  - key_word and key_last are held stable while key_valid && !key_ready.
  - After the last transfer: key_valid drops, done=1 for one cycle, go to IDLE.
- Latency: an accepted start at cycle 0 gives puf_enable=1 from cycle 1. First key_valid appears at cycle 1+SETTLE_CYCLES+(N_SAMPLES−1)*(SAMPLE_GAP+1)+1+1 (= 35 for defaults).
- Boundary conditions:
  - start while busy is ignored; challenge is not relatched.
  - start is accepted in the same cycle done pulses? No: done coincides with the return to IDLE, and start is honoured from the following cycle.
  - Reset mid-operation: immediate return to IDLE with puf_enable=0 and outputs cleared. The stored key is discarded; unstable_cnt is also cleared to 0.
  - Vote counter width is clog2(N_SAMPLES+1) = 3 bits at the default and cannot overflow.
  - N_SAMPLES=1: every bit counts as unanimous, so unstable_cnt=0.
  - SAMPLE_GAP=0: snapshots are taken on consecutive cycles.
  - key_ready held high: one word transfers per cycle, so 32 words take 32 cycles.

Decomposition:
- Shared package puf_pkg holds:
  - state enum (IDLE, ARM, SAMPLE, RESOLVE, STREAM)
  - PUF_W=1024 constant
  - VOTE_W function, clog2(N_SAMPLES+1)
- One sub-module, puf_vote_cell: a single-bit vote counter with clear, increment-enable and data inputs.
  - Outputs the majority bit and the unanimous flag.
  - Generated PUF_W times.
- unstable_cnt is a population count over the inverted unanimous flags, computed in RESOLVE.

Test Plan:
1. Defaults; puf_resp constant 0xA5 repeated; start with challenge=2'b10 → puf_enable high cycles 1–33 with puf_ctrl=2'b10; 32 words of 0xA5A5A5A5; key_last on word 31; unstable_cnt=0; done 1 cycle.
2. puf_resp bit 0 =1 in 2 of 5 snapshots, all other bits 0 → key bit 0 =0; unstable_cnt=1. Then bit 0 =1 in 3 of 5 → word 0 = 0x00000001; unstable_cnt=1.
3. key_ready low for 4 cycles at word 7, otherwise high → key_word for word 7 held stable across the stall; total 32 transfers; no word skipped or duplicated.
4. start pulsed again during SAMPLE with challenge=2'b01 → ignored; puf_ctrl remains the first challenge; exactly one done pulse.
5. rst_n asserted during STREAM at word 12 → puf_enable, key_valid, busy, done, unstable_cnt all 0 asynchronously. A subsequent start runs a full fresh read.
6. N_SAMPLES=1, SAMPLE_GAP=0, puf_resp random value R → key equals R sampled on the first SAMPLE cycle; unstable_cnt=0.
